// File: rtl/multi_vco_startup_seq.sv
// Startup sequencer: serial gain load, staged VCO/amp reset release, VCO frequency race.
// Optional macro RECAL_EN: periodic re-measurement while in DONE.
module multi_vco_startup_seq #(
  parameter  int N_CH     = 2,
  parameter  int GAIN_W   = 3,
  parameter  int WAIT_CFG = 5,
  parameter  int WAIT_VCO = 20,
  parameter  int WAIT_AMP = 10,
  parameter  int MEAS_CYC = 64,
  parameter  int CNT_W    = 8,
  localparam int IDX_W    = $clog2((N_CH > 1) ? N_CH : 2)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_sclk,
  input  logic                   i_sdin,
  input  logic [N_CH-1:0]        i_clk_vco,
  output logic [N_CH*GAIN_W-1:0] o_gain,
  output logic [N_CH-1:0]        o_resetb_vco,
  output logic [N_CH-1:0]        o_resetb_amp,
  output logic [IDX_W-1:0]       o_fast_idx,
  output logic [CNT_W-1:0]       o_fast_cnt,
  output logic                   o_ready
);
  localparam int CFG_W = N_CH * GAIN_W;

  typedef enum logic [3:0] {
    S_CFG, S_WAIT_C, S_VCO_ON, S_WAIT_V, S_AMP_ON, S_WAIT_A, S_MEAS, S_CMP, S_DONE
  } state_t;

  state_t                      r_state, w_next;
  logic [1:0]                  r_rst_sync;
  logic                        w_rst;
  logic [2:0]                  r_sclk_s;
  logic [1:0]                  r_sdin_s;
  logic [N_CH-1:0]             r_vco_s1, r_vco_s2, r_vco_s3;
  logic [CFG_W-1:0]            r_sr;
  logic [31:0]                 r_bcnt, r_wcnt;
  logic [N_CH-1:0][CNT_W-1:0]  r_cnt;
  logic [IDX_W-1:0]            r_scan, r_best_idx;
  logic [CNT_W-1:0]            r_best_cnt, w_scan_cnt;
  logic                        w_sclk_rise, w_load, w_meas_entry, w_cmp_entry, w_cmp_last, w_better;
  logic [N_CH-1:0]             w_vco_rise;
  logic [CFG_W-1:0]            w_sr_next;

  // Reset asserts asynchronously but releases on a clock edge.
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_rst_sync <= 2'b11;
    else         r_rst_sync <= {r_rst_sync[0], 1'b0};
  assign w_rst = r_rst_sync[1];

  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) begin
      r_sclk_s <= '0;
      r_sdin_s <= '0;
      r_vco_s1 <= '0;
      r_vco_s2 <= '0;
      r_vco_s3 <= '0;
    end else begin
      r_sclk_s <= {r_sclk_s[1:0], i_sclk};
      r_sdin_s <= {r_sdin_s[0], i_sdin};
      r_vco_s1 <= i_clk_vco;
      r_vco_s2 <= r_vco_s1;
      r_vco_s3 <= r_vco_s2;
    end

  assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
  assign w_vco_rise  = r_vco_s2 & ~r_vco_s3;
  assign w_sr_next   = CFG_W'({r_sr, r_sdin_s[1]});
  assign w_load      = (r_state == S_CFG) && w_sclk_rise && (r_bcnt == 32'(CFG_W - 1));
  assign w_scan_cnt  = r_cnt[r_scan];
  assign w_better    = w_scan_cnt > r_best_cnt;
  assign w_cmp_last  = (r_state == S_CMP) && (r_scan == IDX_W'(N_CH - 1));

  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) r_state <= S_CFG;
    else       r_state <= w_next;

  // Zero-length waits are skipped by jumping straight past the wait state.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_CFG:    if (w_load) w_next = (WAIT_CFG == 0) ? S_VCO_ON : S_WAIT_C;
      S_WAIT_C: if (r_wcnt == 32'(WAIT_CFG - 1)) w_next = S_VCO_ON;
      S_VCO_ON: w_next = (WAIT_VCO == 0) ? S_AMP_ON : S_WAIT_V;
      S_WAIT_V: if (r_wcnt == 32'(WAIT_VCO - 1)) w_next = S_AMP_ON;
      S_AMP_ON: w_next = (WAIT_AMP == 0) ? S_MEAS : S_WAIT_A;
      S_WAIT_A: if (r_wcnt == 32'(WAIT_AMP - 1)) w_next = S_MEAS;
      S_MEAS:   if (r_wcnt == 32'(MEAS_CYC - 1)) w_next = S_CMP;
      S_CMP:    if (w_cmp_last) w_next = S_DONE;
`ifdef RECAL_EN
      S_DONE:   if (r_wcnt == 32'd1023) w_next = S_MEAS;
`else
      S_DONE:   w_next = S_DONE;
`endif
      default:  w_next = S_CFG;
    endcase
  end

  assign w_meas_entry = (w_next == S_MEAS) && (r_state != S_MEAS);
  assign w_cmp_entry  = (w_next == S_CMP) && (r_state != S_CMP);

  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) begin
      r_wcnt <= '0;
      r_bcnt <= '0;
      r_sr   <= '0;
    end else begin
      r_wcnt <= (w_next != r_state) ? '0 : r_wcnt + 32'd1;
      if (r_state == S_CFG && w_sclk_rise) begin
        r_sr   <= w_sr_next;
        r_bcnt <= r_bcnt + 32'd1;
      end
    end

  // Edge counters run only inside the measurement window and saturate.
  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) r_cnt <= '0;
    else if (w_meas_entry) r_cnt <= '0;
    else if (r_state == S_MEAS)
      for (int k = 0; k < N_CH; k++)
        if (w_vco_rise[k] && r_cnt[k] != '1) r_cnt[k] <= r_cnt[k] + CNT_W'(1);

  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) begin
      r_scan     <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (w_cmp_entry) begin
      r_scan     <= '0;
      r_best_idx <= '0;
      r_best_cnt <= '0;
    end else if (r_state == S_CMP) begin
      r_scan <= r_scan + IDX_W'(1);
      if (w_better) begin
        r_best_idx <= r_scan;
        r_best_cnt <= w_scan_cnt;
      end
    end

  always_ff @(posedge i_clk or posedge w_rst)
    if (w_rst) begin
      o_gain       <= '0;
      o_resetb_vco <= '0;
      o_resetb_amp <= '0;
      o_fast_idx   <= '0;
      o_fast_cnt   <= '0;
      o_ready      <= 1'b0;
    end else begin
      if (w_load)               o_gain       <= w_sr_next;
      if (r_state == S_VCO_ON)  o_resetb_vco <= '1;
      if (r_state == S_AMP_ON)  o_resetb_amp <= '1;
      // Result is published only once the whole scan is complete.
      if (w_cmp_last) begin
        o_fast_idx <= w_better ? r_scan : r_best_idx;
        o_fast_cnt <= w_better ? w_scan_cnt : r_best_cnt;
        o_ready    <= 1'b1;
      end
    end
endmodule
